// File: rtl/dma_copy_if.sv
// Control, status and memory-port signals of the byte-copy DMA.
// The slave modport is the DMA side; the master modport is the requester/memory side.
interface dma_copy_if #(
  parameter int DW = 8
);
   logic          start;
   logic [7:0]    src;
   logic [7:0]    dst;
   logic [5:0]    len;
   logic          abort;
   logic [DW-1:0] rd;
   logic [7:0]    ad;
   logic [DW-1:0] wd;
   logic          mw;
   logic          mr;
   logic          busy;
   logic          done;
   logic          err;
   logic [5:0]    count;

   modport slave (
      input  start, src, dst, len, abort, rd,
      output ad, wd, mw, mr, busy, done, err, count
   );

   modport master (
      output start, src, dst, len, abort, rd,
      input  ad, wd, mw, mr, busy, done, err, count
   );
endinterface

// File: rtl/dma_copy.sv
// Byte-at-a-time memory-to-memory copy engine: one read cycle and one write cycle per byte,
// ascending addresses, with range checking, abort and a one-cycle completion pulse.
module dma_copy #(
   parameter int DEPTH = 32,
   parameter int DW    = 8
) (
   input logic       clk,
   input logic       rst_n,
   dma_copy_if.slave bus
);

   typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_FIN} state_t;

   typedef struct packed {
      logic [7:0] src;
      logic [7:0] dst;
      logic [5:0] len;
   } req_t;

   state_t        state, state_nxt;
   req_t          req_q, req_nxt;
   logic [5:0]    count_q, count_nxt;
   logic          err_q, err_nxt;
   logic [DW-1:0] data_q, data_nxt;

   logic [8:0]    src_end, dst_end;
   logic          range_bad;
   logic [5:0]    count_inc;
   logic          last_byte;

   // Nine-bit sums so an 8-bit address plus the length cannot wrap past the limit.
   assign src_end   = {1'b0, bus.src} + {3'b000, bus.len};
   assign dst_end   = {1'b0, bus.dst} + {3'b000, bus.len};
   assign range_bad = (src_end > 9'(DEPTH)) || (dst_end > 9'(DEPTH));
   assign count_inc = count_q + 6'd1;
   assign last_byte = (count_inc == req_q.len);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= S_IDLE;
         req_q   <= '0;
         count_q <= '0;
         err_q   <= 1'b0;
         data_q  <= '0;
      end else begin
         state   <= state_nxt;
         req_q   <= req_nxt;
         count_q <= count_nxt;
         err_q   <= err_nxt;
         data_q  <= data_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      req_nxt   = req_q;
      count_nxt = count_q;
      err_nxt   = err_q;
      data_nxt  = data_q;
      case (state)
         S_IDLE: begin
            if (bus.start) begin
               req_nxt   = '{src: bus.src, dst: bus.dst, len: bus.len};
               count_nxt = '0;
               err_nxt   = range_bad;
               state_nxt = (range_bad || bus.len == 6'd0) ? S_FIN : S_RD;
            end
         end
         S_RD: begin
            if (bus.abort) begin
               state_nxt = S_IDLE;
            end else begin
               data_nxt  = bus.rd;
               state_nxt = S_WR;
            end
         end
         S_WR: begin
            // The write on this edge always commits, even when aborting.
            count_nxt = count_inc;
            if (bus.abort)      state_nxt = S_IDLE;
            else if (last_byte) state_nxt = S_FIN;
            else                state_nxt = S_RD;
         end
         S_FIN:   state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Memory port and status are decoded from state so reset clears them without waiting for a clock.
   always_comb begin
      bus.ad   = '0;
      bus.wd   = '0;
      bus.mr   = 1'b0;
      bus.mw   = 1'b0;
      bus.busy = 1'b0;
      bus.done = 1'b0;
      case (state)
         S_RD: begin
            bus.ad   = req_q.src + {2'b00, count_q};
            bus.mr   = 1'b1;
            bus.busy = 1'b1;
         end
         S_WR: begin
            bus.ad   = req_q.dst + {2'b00, count_q};
            bus.wd   = data_q;
            bus.mw   = 1'b1;
            bus.busy = 1'b1;
         end
         S_FIN:   bus.done = 1'b1;
         default: ;
      endcase
   end

   assign bus.count = count_q;
   assign bus.err   = err_q;

endmodule

// File: tb/tb_dma_copy.sv
// Directed bench for dma_copy: a vector table of transfers over a 32-byte memory model,
// plus hand-written overlap, abort and mid-transfer reset sequences.
module tb_dma_copy;

   logic clk;
   logic rst_n;

   dma_copy_if #(.DW(8)) bus ();

   dma_copy #(.DEPTH(32), .DW(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory model: single writer process; preloads go through fill_img/fill_req.
   logic [7:0] mem      [0:31];
   logic [7:0] fill_img [0:31];
   logic       fill_req;

   always @(posedge clk) begin
      if (bus.mw)        mem[bus.ad[4:0]] <= bus.wd;
      else if (fill_req) for (int i = 0; i < 32; i++) mem[i] <= fill_img[i];
   end

   assign bus.rd = bus.mr ? mem[bus.ad[4:0]] : 8'h00;

   int mr_tot, mw_tot, both_tot, done_tot;
   initial begin
      mr_tot = 0; mw_tot = 0; both_tot = 0; done_tot = 0;
   end
   always @(negedge clk) begin
      if (bus.mr)           mr_tot++;
      if (bus.mw)           mw_tot++;
      if (bus.mr && bus.mw) both_tot++;
      if (bus.done)         done_tot++;
   end

   int n_cmp, n_bad;

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic fill_ramp();
      for (int i = 0; i < 32; i++) fill_img[i] = 8'(i);
   endtask

   task automatic preload();
      fill_req = 1'b1;
      @(posedge clk);
      #1 fill_req = 1'b0;
   endtask

   // Leaves the bench 1 time unit after the START edge.
   task automatic start_xfer(input int s, input int d, input int l);
      bus.src   = 8'(s);
      bus.dst   = 8'(d);
      bus.len   = 6'(l);
      bus.start = 1'b1;
      @(posedge clk);
      #1 bus.start = 1'b0;
   endtask

   // Counts further edges after the START edge until DONE is seen, bounded.
   task automatic wait_done(output int n);
      n = 0;
      while (!bus.done && n < 200) begin
         @(posedge clk);
         #1 n++;
      end
   endtask

   typedef struct {
      int src;
      int dst;
      int len;
      int exp_err;
      int exp_lat;
      int exp_first;
   } vec_t;

   vec_t vt [8];

   initial begin
      int n, mr0, mw0, dn0;
      n_cmp = 0; n_bad = 0;

      vt[0] = '{src: 2,  dst: 20, len: 3,  exp_err: 0, exp_lat: 6,  exp_first: 2};
      vt[1] = '{src: 0,  dst: 10, len: 0,  exp_err: 0, exp_lat: 0,  exp_first: 0};
      vt[2] = '{src: 30, dst: 0,  len: 3,  exp_err: 1, exp_lat: 0,  exp_first: 0};
      vt[3] = '{src: 5,  dst: 8,  len: 1,  exp_err: 0, exp_lat: 2,  exp_first: 5};
      vt[4] = '{src: 29, dst: 0,  len: 3,  exp_err: 0, exp_lat: 6,  exp_first: 29};
      vt[5] = '{src: 0,  dst: 16, len: 16, exp_err: 0, exp_lat: 32, exp_first: 0};
      vt[6] = '{src: 10, dst: 31, len: 2,  exp_err: 1, exp_lat: 0,  exp_first: 0};
      vt[7] = '{src: 0,  dst: 0,  len: 32, exp_err: 0, exp_lat: 64, exp_first: 0};

      rst_n = 1'b0; fill_req = 1'b0;
      bus.start = 1'b0; bus.abort = 1'b0;
      bus.src = '0; bus.dst = '0; bus.len = '0;
      fill_ramp();

      #1;
      chk("rst_ad",    int'(bus.ad),    0);
      chk("rst_wd",    int'(bus.wd),    0);
      chk("rst_mr",    int'(bus.mr),    0);
      chk("rst_mw",    int'(bus.mw),    0);
      chk("rst_busy",  int'(bus.busy),  0);
      chk("rst_done",  int'(bus.done),  0);
      chk("rst_err",   int'(bus.err),   0);
      chk("rst_count", int'(bus.count), 0);
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;

      for (int v = 0; v < 8; v++) begin
         fill_ramp();
         preload();
         mr0 = mr_tot; mw0 = mw_tot;
         start_xfer(vt[v].src, vt[v].dst, vt[v].len);
         wait_done(n);
         chk($sformatf("v%0d_latency", v), n, vt[v].exp_lat);
         chk($sformatf("v%0d_err", v), int'(bus.err), vt[v].exp_err);
         @(posedge clk);
         #1;
         chk($sformatf("v%0d_done_drop", v), int'(bus.done), 0);
         chk($sformatf("v%0d_busy_idle", v), int'(bus.busy), 0);
         chk($sformatf("v%0d_count", v), int'(bus.count), vt[v].exp_err ? 0 : vt[v].len);
         chk($sformatf("v%0d_err_hold", v), int'(bus.err), vt[v].exp_err);
         chk($sformatf("v%0d_reads", v), mr_tot - mr0, vt[v].exp_err ? 0 : vt[v].len);
         chk($sformatf("v%0d_writes", v), mw_tot - mw0, vt[v].exp_err ? 0 : vt[v].len);
         if (!vt[v].exp_err)
            for (int k = 0; k < vt[v].len; k++)
               chk($sformatf("v%0d_mem[%0d]", v, vt[v].dst + k),
                   int'(mem[vt[v].dst + k]), vt[v].exp_first + k);
      end

      // Overlapping regions with dst > src replicate the first source byte.
      fill_ramp();
      fill_img[0] = 8'hA0; fill_img[1] = 8'hA1; fill_img[2] = 8'hA2; fill_img[3] = 8'hA3;
      preload();
      start_xfer(0, 1, 3);
      wait_done(n);
      chk("ovl_latency", n, 6);
      @(posedge clk);
      #1;
      chk("ovl_mem1", int'(mem[1]), 'hA0);
      chk("ovl_mem2", int'(mem[2]), 'hA0);
      chk("ovl_mem3", int'(mem[3]), 'hA0);
      chk("ovl_mem4", int'(mem[4]), 4);

      // Abort in the second write, with a stray START issued during the first read.
      fill_ramp();
      for (int i = 16; i < 20; i++) fill_img[i] = 8'hFF;
      preload();
      dn0 = done_tot;
      start_xfer(0, 16, 4);
      bus.src = 8'd30; bus.len = 6'd0; bus.start = 1'b1;
      @(posedge clk);
      #1 bus.start = 1'b0;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      chk("abt_in_wr2", int'(bus.mw), 1);
      bus.abort = 1'b1;
      @(posedge clk);
      #1 bus.abort = 1'b0;
      chk("abt_busy",  int'(bus.busy),  0);
      chk("abt_done",  int'(bus.done),  0);
      chk("abt_count", int'(bus.count), 2);
      chk("abt_err",   int'(bus.err),   0);
      chk("abt_mem16", int'(mem[16]), 0);
      chk("abt_mem17", int'(mem[17]), 1);
      chk("abt_mem18", int'(mem[18]), 'hFF);
      repeat (3) @(posedge clk);
      #1;
      chk("abt_no_done", done_tot - dn0, 0);
      chk("abt_count_hold", int'(bus.count), 2);

      // Asynchronous reset while reading byte 2.
      preload();
      mw0 = mw_tot;
      start_xfer(0, 16, 4);
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      chk("rmid_in_rd2", int'(bus.mr), 1);
      #2 rst_n = 1'b0;
      #1;
      chk("rmid_ad",    int'(bus.ad),    0);
      chk("rmid_mr",    int'(bus.mr),    0);
      chk("rmid_mw",    int'(bus.mw),    0);
      chk("rmid_busy",  int'(bus.busy),  0);
      chk("rmid_done",  int'(bus.done),  0);
      chk("rmid_count", int'(bus.count), 0);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rmid_writes", mw_tot - mw0, 1);
      chk("rmid_mem16", int'(mem[16]), 0);
      chk("rmid_mem17", int'(mem[17]), 'hFF);

      chk("mr_mw_overlap", both_tot, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/dma_copy.md
DMA_COPY -- requirements
Module: dma_copy

Interface
REQ-001 Parameter DEPTH, default 32, number of addressable memory bytes; legal addresses are 0..DEPTH-1.
REQ-002 Parameter DW, default 8, data width in bits.
REQ-003 CLK  input  1  single clock; all state changes occur on the rising edge.
REQ-004 RESET  input  1  asynchronous, active-low reset; RESET=0 forces reset state immediately, independent of CLK.
REQ-005 START  input  1  request pulse; sampled on the rising edge in IDLE only.
REQ-006 SRC  input  8  first source byte address; captured on an accepted START.
REQ-007 DST  input  8  first destination byte address; captured on an accepted START.
REQ-008 LEN  input  6  byte count, 0..32; captured on an accepted START.
REQ-009 ABORT  input  1  cancel request; sampled on the rising edge in RD or WR.
REQ-010 RD  input  DW  memory read data; combinational from AD while MR=1.
REQ-011 AD  output  8  memory address.
REQ-012 WD  output  DW  memory write data.
REQ-013 MW  output  1  memory write enable; memory writes WD to AD on the rising edge while MW=1.
REQ-014 MR  output  1  memory read enable.
REQ-015 BUSY  output  1  high while in RD or WR.
REQ-016 DONE  output  1  one-cycle completion pulse.
REQ-017 ERR  output  1  range-error flag.
REQ-018 COUNT  output  6  number of bytes written in the current or most recent transfer.

Function
REQ-019 The block SHALL be a four-state FSM: IDLE, RD, WR, FIN.
REQ-020 In IDLE, START=1 SHALL capture SRC, DST and LEN, clear COUNT and clear ERR.
REQ-021 Same edge as REQ-020: if SRC+LEN>DEPTH or DST+LEN>DEPTH (9-bit compare), ERR SHALL be set, the next state SHALL be FIN, and no memory access SHALL occur.
REQ-022 Same edge as REQ-020: if LEN=0, the next state SHALL be FIN and no memory access SHALL occur.
REQ-023 Same edge as REQ-020: otherwise, the next state SHALL be RD.
REQ-024 In RD, outputs SHALL be AD=SRC+COUNT and MR=1; the rising edge SHALL latch RD into an internal data register and go to WR.
REQ-025 In WR, outputs SHALL be AD=DST+COUNT, WD=data register and MW=1; the rising edge SHALL increment COUNT.
REQ-026 Same edge as REQ-025: the next state SHALL be FIN when COUNT+1=LEN, otherwise RD.
REQ-027 Each byte SHALL take exactly 2 cycles; DONE SHALL be high in the cycle beginning 2*LEN edges after the START edge.
REQ-028 FIN SHALL assert DONE for exactly one cycle, then go to IDLE.
REQ-029 MR and MW SHALL never be high in the same cycle.
REQ-030 In IDLE and FIN: MR=0, MW=0, AD=0, WD=0.
REQ-031 Bytes SHALL be copied in ascending address order; overlapping regions with DST>SRC propagate already-written bytes, and this is the defined behaviour.
REQ-032 START SHALL be ignored in RD, WR and FIN.
REQ-033 ABORT=1 in RD SHALL go to IDLE with no write and no DONE.
REQ-034 ABORT=1 in WR SHALL complete that edge's write and COUNT increment, then go to IDLE with no DONE.
REQ-035 COUNT SHALL hold its value in IDLE.
REQ-036 ERR SHALL hold until the next accepted START.

Reset
REQ-037 RESET=0 SHALL immediately force state IDLE, COUNT=0, ERR=0, DONE=0, BUSY=0, MR=0, MW=0, AD=0, WD=0, and clear the data register.
REQ-038 A reset asserted mid-transfer SHALL abandon the transfer with no further memory access; any write already committed on a prior edge stays in memory.

Verification
REQ-039 Preload mem[2..4]=0x02,0x03,0x04; START with SRC=2, DST=20, LEN=3 -> mem[20..22]=0x02,0x03,0x04; DONE exactly 6 cycles after START; COUNT=3; ERR=0.
REQ-040 START with LEN=0 -> DONE on the next cycle, MR and MW never asserted, COUNT=0.
REQ-041 START with SRC=30, LEN=3 -> ERR=1, DONE pulse, no MR/MW; a following valid START -> ERR=0.
REQ-042 Preload mem[0..3]=0xA0..0xA3; START with SRC=0, DST=1, LEN=3 -> mem[1..3]=0xA0,0xA0,0xA0.
REQ-043 LEN=4 with ABORT in the second WR -> exactly 2 bytes written, COUNT=2, no DONE, BUSY=0 next cycle.
REQ-044 RESET=0 asserted asynchronously in RD of byte 2 -> all outputs at reset values before the next edge; only byte 1 written.
